// File: rtl/mem_stage.sv
// MEM stage: latches the EX bus, waits for the data-SRAM response, aligns and extends load data.
// Optional `MEM_FWD_EN adds ms_fwd_bus for ID-stage bypass and load-use stall detection.
module mem_stage #(
    parameter int BUS_IN_W  = 75,
    parameter int BUS_OUT_W = 70
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 ms_allowin,
    input  logic                 es_to_ms_valid,
    input  logic [BUS_IN_W-1:0]  es_to_ms_bus,
    input  logic                 ws_allowin,
    output logic                 ms_to_ws_valid,
    output logic [BUS_OUT_W-1:0] ms_to_ws_bus,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata
`ifdef MEM_FWD_EN
    ,
    output logic [38:0]          ms_fwd_bus
`endif
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    logic [1:0]          state;
    // mem_req is consumed by the state transition, so it is not kept in the latched bus
    logic [BUS_IN_W-2:0] bus_r;
    logic [31:0]         rdata_buf;

    logic        ms_ready_go;
    logic        accept;
    logic [2:0]  load_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [1:0]  offset;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign load_op      = bus_r[73:71];
    assign res_from_mem = bus_r[70];
    assign gr_we        = bus_r[69];
    assign dest         = bus_r[68:64];
    assign alu_result   = bus_r[63:32];
    assign pc           = bus_r[31:0];

    assign ms_ready_go    = (state == READY);
    assign ms_allowin     = (state == EMPTY) || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_ready_go;
    assign accept         = es_to_ms_valid && ms_allowin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            bus_r     <= '0;
            rdata_buf <= '0;
        end else if (accept) begin
            bus_r <= es_to_ms_bus[BUS_IN_W-2:0];
            state <= es_to_ms_bus[BUS_IN_W-1] ? WAIT : READY;
        end else if (ms_ready_go && ws_allowin) begin
            state <= EMPTY;
        end else if (state == WAIT && data_sram_data_ok) begin
            state     <= READY;
            rdata_buf <= data_sram_rdata;
        end
    end

    assign offset   = alu_result[1:0];
    assign sel_byte = rdata_buf[{offset, 3'b000} +: 8];
    assign sel_half = rdata_buf[{offset[1], 4'b0000} +: 16];

    always_comb begin
        load_data = rdata_buf;
        case (load_op)
            3'b001:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b010:  load_data = {24'd0, sel_byte};
            3'b011:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_data = {16'd0, sel_half};
            default: load_data = rdata_buf;
        endcase
    end

    assign final_result = res_from_mem ? load_data : alu_result;
    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

`ifdef MEM_FWD_EN
    assign ms_fwd_bus = {(state != EMPTY) && gr_we, ms_ready_go, dest, final_result};
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed scenarios plus randomized traffic against a
// field-level reference model; a negedge monitor pops expected WB-bus words on each handshake.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ms_allowin;
    logic        es_to_ms_valid = 1'b0;
    logic [74:0] es_to_ms_bus = '0;
    logic        ws_allowin = 1'b1;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = '0;
`ifdef MEM_FWD_EN
    logic [38:0] ms_fwd_bus;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit ws_rand = 1'b0;
    logic [69:0] exp_q[$];

    mem_stage #(.BUS_IN_W(75), .BUS_OUT_W(70)) dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
`ifdef MEM_FWD_EN
        ,
        .ms_fwd_bus        (ms_fwd_bus)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pick the addressed byte/half with shifts and modulo, extend arithmetically.
    function automatic logic [69:0] model(input logic [2:0] lop, input bit rfm, input bit gwe,
                                          input logic [4:0] dst, input logic [31:0] alu,
                                          input logic [31:0] pc, input logic [31:0] rd);
        int unsigned off, b, h;
        logic [31:0] r;
        off = alu % 4;
        b = (rd >> (off * 8)) % 256;
        h = (rd >> ((off / 2) * 16)) % 65536;
        case (lop)
            3'd1:    r = (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd2:    r = b;
            3'd3:    r = (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    r = h;
            default: r = rd;
        endcase
        return {gwe, dst, rfm ? r : alu, pc};
    endfunction

    // Called just after a posedge; returns just after the edge where the result became ready.
    task automatic issue(input bit mreq, input logic [2:0] lop, input bit rfm, input bit gwe,
                         input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] rd, input int dly);
        int n;
        logic [95:0] junk;
        n = 0;
        es_to_ms_bus = {mreq, lop, rfm, gwe, dst, alu, pc};
        es_to_ms_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (ms_allowin) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 70'(ms_allowin), 70'd1);
                es_to_ms_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(model(lop, rfm, gwe, dst, alu, pc, rd));
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
        if (mreq) begin
            for (int i = 0; i < dly; i++) begin
                junk = {$urandom(), $urandom(), $urandom()};
                es_to_ms_bus = junk[74:0];
                es_to_ms_valid = 1'b1;
                @(negedge clk);
                chk("wait_valid", 70'(ms_to_ws_valid), 70'd0);
                chk("wait_allowin", 70'(ms_allowin), 70'd0);
`ifdef MEM_FWD_EN
                if (!gwe) chk("fwd_store_we", 70'(ms_fwd_bus[38]), 70'd0);
                chk("fwd_wait_ready", 70'(ms_fwd_bus[37]), 70'd0);
`endif
                @(posedge clk); #1;
            end
            es_to_ms_valid = 1'b0;
            data_sram_data_ok = 1'b1;
            data_sram_rdata = rd;
            @(posedge clk); #1;
            data_sram_data_ok = 1'b0;
            data_sram_rdata = $urandom();
        end
        chk("latency_valid", 70'(ms_to_ws_valid), 70'd1);
`ifdef MEM_FWD_EN
        chk("fwd_we", 70'(ms_fwd_bus[38]), 70'(gwe));
`endif
    endtask

    task automatic drain();
        int n;
        n = 0;
        ws_rand = 1'b0;
        ws_allowin = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 70'(exp_q.size()), 70'd0);
    endtask

    // WB back-pressure
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ws_rand) ws_allowin = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every WB handshake must match the oldest expected result.
    initial begin
        logic [69:0] e;
        forever begin
            @(negedge clk);
            if (!reset && ms_to_ws_valid && ws_allowin) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 70'(ms_to_ws_valid), 70'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_bus", ms_to_ws_bus, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit mreq, rfm, gwe;
        int kind;
        @(posedge clk); #1;
        chk("rst_valid", 70'(ms_to_ws_valid), 70'd0);
        chk("rst_bus", ms_to_ws_bus, 70'd0);
        chk("rst_allowin", 70'(ms_allowin), 70'd1);
`ifdef MEM_FWD_EN
        chk("rst_fwd", 70'(ms_fwd_bus), 70'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        // ALU ops back to back
        issue(1'b0, 3'd0, 1'b0, 1'b1, 5'd5, 32'h12345678, 32'h1C000000, 32'h0, 0);
        chk("alu_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h12345678, 32'h1C000000});
        chk("alu_allowin", 70'(ms_allowin), 70'd1);
        issue(1'b0, 3'd0, 1'b0, 1'b1, 5'd6, 32'h0000ABCD, 32'h1C000004, 32'h0, 0);

        // Load extraction
        issue(1'b1, 3'd1, 1'b1, 1'b1, 5'd7, 32'h1C001003, 32'h1C000008, 32'h80FF7F01, 2);
        chk("lb_off3", 70'(ms_to_ws_bus[63:32]), 70'(32'hFFFFFF80));
        issue(1'b1, 3'd2, 1'b1, 1'b1, 5'd8, 32'h1C001002, 32'h1C00000C, 32'h80FF7F01, 1);
        chk("lbu_off2", 70'(ms_to_ws_bus[63:32]), 70'(32'h000000FF));
        issue(1'b1, 3'd3, 1'b1, 1'b1, 5'd9, 32'h1C001002, 32'h1C000010, 32'h80FF7F01, 0);
        chk("lh_off2", 70'(ms_to_ws_bus[63:32]), 70'(32'hFFFF80FF));
        issue(1'b1, 3'd4, 1'b1, 1'b1, 5'd10, 32'h1C001000, 32'h1C000014, 32'h80FF7F01, 0);
        chk("lhu_off0", 70'(ms_to_ws_bus[63:32]), 70'(32'h00007F01));

        // Long WAIT stall with EX bus churn
        issue(1'b1, 3'd0, 1'b1, 1'b1, 5'd11, 32'h1C002000, 32'h1C000018, 32'hCAFEF00D, 5);
        chk("wait5_lw", 70'(ms_to_ws_bus[63:32]), 70'(32'hCAFEF00D));

        // Store completes with gr_we=0
        issue(1'b1, 3'd0, 1'b0, 1'b0, 5'd12, 32'h1C003000, 32'h1C00001C, 32'h0, 1);
        chk("store_we", 70'(ms_to_ws_bus[69]), 70'd0);
        drain();

        // Stall while READY
        ws_allowin = 1'b0;
        issue(1'b1, 3'd0, 1'b1, 1'b1, 5'd13, 32'h1C004000, 32'h1C000020, 32'hDEADBEEF, 1);
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 70'(ms_to_ws_valid), 70'd1);
            chk("stall_data", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEADBEEF));
        end
        @(posedge clk); #1;
        ws_allowin = 1'b1;
        @(posedge clk); #1;
        chk("stall_done", 70'(ms_to_ws_valid), 70'd0);
        drain();

        // Reset while a load waits, then a stale response
        es_to_ms_bus = {1'b1, 3'd0, 1'b1, 1'b1, 5'd14, 32'h1C005000, 32'h1C000024};
        es_to_ms_valid = 1'b1;
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
        chk("pre_rst_allowin", 70'(ms_allowin), 70'd0);
        #2 reset = 1'b1;
        #1;
        chk("amid_rst_valid", 70'(ms_to_ws_valid), 70'd0);
        chk("amid_rst_bus", ms_to_ws_bus, 70'd0);
        chk("amid_rst_allowin", 70'(ms_allowin), 70'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h55555555;
        @(posedge clk); #1;
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("stale_valid", 70'(ms_to_ws_valid), 70'd0);
        chk("stale_allowin", 70'(ms_allowin), 70'd1);
        chk("stale_bus", ms_to_ws_bus, 70'd0);
        @(posedge clk); #1;

        // Randomized traffic with random WB back-pressure
        ws_rand = 1'b1;
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 2);
            mreq = (kind != 0);
            rfm  = (kind == 1);
            gwe  = (kind == 0) ? 1'($urandom_range(0, 1)) : (kind == 1);
            issue(mreq, 3'($urandom_range(0, 7)), rfm, gwe, 5'($urandom()), $urandom(),
                  $urandom(), $urandom(), $urandom_range(0, 3));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage in-order pipeline, placed between EX and WB.
- Latches the EX-stage bus and waits for the data-SRAM response when the instruction issued a memory request.
- Extracts, aligns and sign/zero-extends load data.
- Drives the 70-bit {gr_we, dest, final_result, pc} bus and its valid signal to WB under the valid/allowin handshake.

Parameters:
- BUS_IN_W, 75, width of es_to_ms_bus.
- BUS_OUT_W, 70, width of ms_to_ws_bus (fixed by the WB interface).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high.
- ms_allowin  out  1  MEM can accept a new instruction this cycle.
- es_to_ms_valid  in  1  EX presents a valid instruction.
- es_to_ms_bus  in  75  {mem_req, load_op[2:0], res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}, MSB first.
- ws_allowin  in  1  WB can accept.
- ms_to_ws_valid  out  1  MEM output valid.
- ms_to_ws_bus  out  70  {gr_we, dest[4:0], final_result[31:0], pc[31:0]}, MSB first.
- data_sram_data_ok  in  1  one-cycle pulse: response for the oldest outstanding request.
- data_sram_rdata  in  32  response data, valid with data_ok.
- ms_fwd_bus  out  39  present only with MEM_FWD_EN; see Optional Feature.

Behaviour:
- Reset: asynchronous, active-high.
  - state=EMPTY, ms_valid=0, all bus registers and the data buffer cleared to 0.
  - ms_to_ws_valid=0, ms_to_ws_bus=0, ms_allowin=1.
- States:
  - EMPTY: no instruction held.
  - WAIT: instruction held with mem_req=1 and no response yet.
  - READY: instruction held and its result complete.
- Handshakes:
  - ms_ready_go = (state==READY).
  - ms_allowin = (state==EMPTY) || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_ready_go.
  - Accept: es_to_ms_valid && ms_allowin at a clk edge. Latch the bus; next state is WAIT if mem_req=1, else READY.
  - Leave: ms_ready_go && ws_allowin with no accept → EMPTY. Leave and accept in the same cycle → back-to-back, no bubble.
- WAIT → READY on data_sram_data_ok=1; data_sram_rdata is captured into rdata_buf the same edge.
  - While in READY, a stalled WB (ws_allowin=0) holds rdata_buf and all outputs stable.
- data_ok while EMPTY or READY is ignored: no state change, buffer unchanged. This covers a stale response after reset.
- Load extraction: offset = alu_result[1:0]. Selected byte = rdata_buf[8*offset+:8]; selected half = rdata_buf[16*offset[1]+:16].
  - load_op 000 LW: word.
  - 001 LB: sign-extended byte.
  - 010 LBU: zero-extended byte.
  - 011 LH: sign-extended half.
  - 100 LHU: zero-extended half.
  - Other encodings: treated as LW.
- final_result = res_from_mem ? extracted load data : alu_result.
- Stores: mem_req=1, res_from_mem=0, gr_we=0. The stage still waits for data_ok so store completion is ordered.
- Misaligned offsets for LW/LH are not checked here (handled upstream); the extraction rule above still applies.
- Latency:
  - Non-memory op: one cycle from accept to ms_to_ws_valid.
  - Memory op: data_ok cycle + 1.
- ms_to_ws_bus is combinational from registered state and buffer only. There is no combinational path from es_to_ms_* to ms_to_ws_*.
- ms_allowin does depend combinationally on ws_allowin.

Optional Feature:
- Macro: MEM_FWD_EN.
- Defined: port ms_fwd_bus[38:0] = {ms_valid && gr_we, ms_ready_go, dest[4:0], final_result[31:0]}, for ID-stage bypass and load-use stall detection.
  - ms_valid = (state!=EMPTY).
  - Bit 37 low means the result is not yet available (load in WAIT).
  - Reset value 0.
- Undefined: port absent; no extra logic.

Test Plan:
- ALU op: accept {mem_req=0, gr_we=1, dest=5, alu_result=0x12345678, pc=0x1C000000} with ws_allowin=1.
  - Next cycle ms_to_ws_valid=1, bus={1, 5, 0x12345678, 0x1C000000}.
  - ms_allowin stays 1 for back-to-back ops.
- LB with offset 3: data_ok arrives 2 cycles after accept with rdata=0x80FF7F01.
  - final_result=0xFFFFFF80.
  - Same rdata with LBU at offset 2 gives 0x000000FF.
  - LH at offset 2 gives 0xFFFF80FF.
  - LHU at offset 0 gives 0x00007F01.
- Stall while waiting: load in WAIT with no data_ok for 5 cycles.
  - ms_to_ws_valid=0, ms_allowin=0.
  - EX bus changes are not latched.
- Stall while ready: data_ok=1 with rdata=0xDEADBEEF (LW) while ws_allowin=0 for 3 cycles.
  - Output holds 0xDEADBEEF and valid=1 throughout.
  - Completes on the first ws_allowin=1.
- Reset mid-WAIT: assert reset asynchronously.
  - Outputs 0 immediately.
  - A data_ok arriving after reset with rdata=0x55555555 is ignored: state stays EMPTY, valid=0.
- Store: mem_req=1, gr_we=0, data_ok after 1 cycle.
  - One ms_to_ws_valid pulse with gr_we=0.
  - With MEM_FWD_EN, ms_fwd_bus[38]=0 throughout.
